axi_slv_req_arbiter: RTL and testbench

//  Shares one downstream simplified request/response port (valid/addr/size/write/wdata/wstrb/last,

---
 rtl/axi_slv_req_arbiter_if.sv | 53 +++++
 rtl/axi_slv_req_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_slv_req_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_req_arbiter_if.sv
// Bundle between NREQ upstream request front-ends, the arbiter and one shared downstream target.
// Latency: none, signal container only.
// Backpressure: i_req_ready / o_req_ready carry the beat handshakes; responses have no backpressure.
interface axi_slv_req_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    localparam int BYTES = DATA_W / 8;

    // upstream side
    logic [NREQ-1:0]              i_req_valid;
    logic [NREQ-1:0][ADDR_W-1:0]  i_req_addr;
    logic [NREQ-1:0][7:0]         i_req_size;
    logic [NREQ-1:0]              i_req_write;
    logic [NREQ-1:0][DATA_W-1:0]  i_req_wdata;
    logic [NREQ-1:0][BYTES-1:0]   i_req_wstrb;
    logic [NREQ-1:0]              i_req_last;
    logic [NREQ-1:0]              o_req_ready;
    logic [NREQ-1:0]              o_resp_valid;
    logic [DATA_W-1:0]            o_resp_rdata;
    logic                         o_resp_err;

    // downstream side
    logic                         o_req_valid;
    logic [ADDR_W-1:0]            o_req_addr;
    logic [7:0]                   o_req_size;
    logic                         o_req_write;
    logic [DATA_W-1:0]            o_req_wdata;
    logic [BYTES-1:0]             o_req_wstrb;
    logic                         o_req_last;
    logic                         i_req_ready;
    logic                         i_resp_valid;
    logic [DATA_W-1:0]            i_resp_rdata;
    logic                         i_resp_err;
    logic                         o_orphan;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_size, i_req_write, i_req_wdata, i_req_wstrb, i_req_last,
        input  i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
        output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        output o_req_valid, o_req_addr, o_req_size, o_req_write, o_req_wdata, o_req_wstrb, o_req_last,
        output o_orphan
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_size, i_req_write, i_req_wdata, i_req_wstrb, i_req_last,
        output i_req_ready, i_resp_valid, i_resp_rdata, i_resp_err,
        input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
        input  o_req_valid, o_req_addr, o_req_size, o_req_write, o_req_wdata, o_req_wstrb, o_req_last,
        input  o_orphan
    );
endinterface

// File: rtl/axi_slv_req_arbiter.sv
// Round-robin, burst-granular sharing of one downstream request/response port between NREQ requesters.
// Latency: 1 arbitration cycle per burst, then beats and responses pass combinationally (0 cycles).
// Backpressure: owner ready follows downstream ready, held low at MAX_OUTSTANDING unanswered beats.
module axi_slv_req_arbiter #(
    parameter int NREQ            = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic i_clk,
    input  logic i_nrst,
    axi_slv_req_arbiter_if.slave bus
);
    localparam int         IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             last_seen_q, last_seen_d;
    logic             orphan_q, orphan_d;

    logic             in_grant;
    logic             gate;
    logic             accept;
    logic             resp_take;
    logic             found;
    int               idx;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            orphan_q    <= orphan_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        last_seen_d  = last_seen_q;
        found        = 1'b0;
        idx          = 0;

        bus.o_req_ready  = '0;
        bus.o_resp_valid = '0;
        bus.o_req_valid  = 1'b0;
        bus.o_req_addr   = '0;
        bus.o_req_size   = '0;
        bus.o_req_write  = 1'b0;
        bus.o_req_wdata  = '0;
        bus.o_req_wstrb  = '0;
        bus.o_req_last   = 1'b0;
        bus.o_resp_rdata = bus.i_resp_rdata;
        bus.o_resp_err   = bus.i_resp_err;
        bus.o_orphan     = orphan_q;

        // Handshakes are suppressed while reset is asserted so no beat is handed off and then forgotten.
        in_grant = i_nrst && (state_q == GRANT);
        gate     = in_grant && (cnt_q < MAX_CNT) && !last_seen_q;

        if (in_grant) begin
            bus.o_req_addr  = bus.i_req_addr[grant_q];
            bus.o_req_size  = bus.i_req_size[grant_q];
            bus.o_req_write = bus.i_req_write[grant_q];
            bus.o_req_wdata = bus.i_req_wdata[grant_q];
            bus.o_req_wstrb = bus.i_req_wstrb[grant_q];
            bus.o_req_last  = bus.i_req_last[grant_q];
        end
        if (gate) begin
            bus.o_req_ready[grant_q] = bus.i_req_ready;
            bus.o_req_valid          = bus.i_req_valid[grant_q];
        end

        accept = bus.o_req_valid && bus.i_req_ready;
        // A response landing in the same cycle as its own beat is matched to that beat, not orphaned.
        resp_take = i_nrst && bus.i_resp_valid && ((cnt_q != 4'd0) || accept);
        bus.o_resp_valid[grant_q] = resp_take;

        cnt_d    = cnt_q + 4'(accept) - 4'(resp_take);
        orphan_d = bus.i_resp_valid && !resp_take;

        case (state_q)
            IDLE: begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (int'(rr_q) + k) % NREQ;
                    if (!found && bus.i_req_valid[idx]) begin
                        found   = 1'b1;
                        grant_d = IDX_W'(idx);
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (accept && bus.i_req_last[grant_q]) begin
                    last_seen_d = 1'b1;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_d == 4'd0) begin
                    state_d     = IDLE;
                    rr_d        = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + IDX_W'(1);
                    last_seen_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_slv_req_arbiter.sv
// Directed scenarios plus randomized bursts against a queue-based model of the arbiter's ordering rules.
`timescale 1ns/1ps
module tb_axi_slv_req_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        last;
    } beat_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int vecs  = 0;
    int fails = 0;
    int cyc   = 0;

    axi_slv_req_arbiter_if #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW)) b8 ();
    axi_slv_req_arbiter_if #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW)) b2 ();

    axi_slv_req_arbiter #(.NREQ(2), .MAX_OUTSTANDING(8), .ADDR_W(AW), .DATA_W(DW)) dut8 (
        .i_clk(clk), .i_nrst(nrst), .bus(b8.slave));
    axi_slv_req_arbiter #(.NREQ(2), .MAX_OUTSTANDING(2), .ADDR_W(AW), .DATA_W(DW)) dut2 (
        .i_clk(clk), .i_nrst(nrst), .bus(b2.slave));

    // reference model: pending beats per requester, owners of unanswered beats, response due times
    beat_t rq [2][$];
    int    out_q[$];
    int    due_q[$];
    int    resp_log[$];
    int    m_owner = -1;
    int    m_rr    = 0;
    bit    mid [2];
    int    last_due = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vecs++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear8();
        b8.i_req_valid = '0; b8.i_req_addr = '0; b8.i_req_size = '0; b8.i_req_write = '0;
        b8.i_req_wdata = '0; b8.i_req_wstrb = '0; b8.i_req_last = '0; b8.i_req_ready = 1'b0;
        b8.i_resp_valid = 1'b0; b8.i_resp_rdata = '0; b8.i_resp_err = 1'b0;
    endtask

    task automatic clear2();
        b2.i_req_valid = '0; b2.i_req_addr = '0; b2.i_req_size = '0; b2.i_req_write = '0;
        b2.i_req_wdata = '0; b2.i_req_wstrb = '0; b2.i_req_last = '0; b2.i_req_ready = 1'b0;
        b2.i_resp_valid = 1'b0; b2.i_resp_rdata = '0; b2.i_resp_err = 1'b0;
    endtask

    task automatic push_burst(input int r, input int len, input logic [31:0] base, input logic wr);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.addr  = base + 32'(4 * i);
            b.size  = 8'd4;
            b.write = wr;
            b.wdata = $urandom;
            b.wstrb = 4'($urandom_range(15));
            b.last  = (i == len - 1);
            rq[r].push_back(b);
        end
    endtask

    task automatic run_engine(input int rdy_pct, input int dmin, input int dmax, input int gap_pct,
                              input int budget);
        int          start;
        int          ow;
        int          d;
        bit          done;
        bit          rv;
        logic [1:0]  ev;
        logic [31:0] rdata;
        logic        rerr;
        beat_t       b;
        start    = cyc;
        done     = 1'b0;
        last_due = cyc;
        while (!done && (cyc - start) < budget) begin
            for (int r = 0; r < 2; r++) begin
                b8.i_req_valid[r] = (rq[r].size() > 0) && !(mid[r] && ($urandom_range(99) < gap_pct));
                if (rq[r].size() > 0) b = rq[r][0];
                else b = beat_t'({$urandom, $urandom, $urandom});
                b8.i_req_addr[r]  = b.addr;
                b8.i_req_size[r]  = b.size;
                b8.i_req_write[r] = b.write;
                b8.i_req_wdata[r] = b.wdata;
                b8.i_req_wstrb[r] = b.wstrb;
                b8.i_req_last[r]  = b.last;
            end
            b8.i_req_ready  = ($urandom_range(99) < rdy_pct);
            rv              = (due_q.size() > 0) && (due_q[0] <= cyc);
            rdata           = $urandom;
            rerr            = 1'($urandom_range(1));
            b8.i_resp_valid = rv;
            b8.i_resp_rdata = rdata;
            b8.i_resp_err   = rerr;
            #1;
            chk("orphan_quiet", b8.o_orphan, 1'b0);
            chk("ready_onehot", ($countones(b8.o_req_ready) <= 1), 1'b1);
            if (m_owner < 0 && out_q.size() > 0) chk("drain_hold", b8.o_req_valid, 1'b0);
            if (m_owner >= 0 && mid[m_owner]) begin
                chk("valid_gate", b8.o_req_valid, b8.i_req_valid[m_owner] && (out_q.size() < 8));
                chk("ready_gate", b8.o_req_ready[m_owner], b8.i_req_ready && (out_q.size() < 8));
            end
            if (b8.o_req_valid) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_owner < 0 && rq[(m_rr + k) % 2].size() > 0) m_owner = (m_rr + k) % 2;
                    end
                end
                if (m_owner < 0) begin
                    chk("spurious_valid", b8.o_req_valid, 1'b0);
                end else begin
                    chk("owner_valid", b8.i_req_valid[m_owner], 1'b1);
                    chk("payload", {b8.o_req_addr, b8.o_req_size, b8.o_req_write, b8.o_req_wdata,
                                    b8.o_req_wstrb, b8.o_req_last}, rq[m_owner][0]);
                    if (b8.i_req_ready) begin
                        chk("owner_ready", b8.o_req_ready[m_owner], 1'b1);
                        b = rq[m_owner].pop_front();
                        out_q.push_back(m_owner);
                        d = $urandom_range(dmax, dmin);
                        last_due = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
                        due_q.push_back(last_due);
                        if (b.last) begin
                            mid[m_owner] = 1'b0;
                            m_rr         = (m_owner + 1) % 2;
                            m_owner      = -1;
                        end else begin
                            mid[m_owner] = 1'b1;
                        end
                    end
                end
            end
            if (rv) begin
                ev = '0;
                ow = (out_q.size() > 0) ? out_q[0] : -1;
                if (ow >= 0) ev[ow] = 1'b1;
                chk("resp_route", b8.o_resp_valid, ev);
                chk("resp_data", {b8.o_resp_err, b8.o_resp_rdata}, {rerr, rdata});
                if (ow >= 0) begin
                    resp_log.push_back(ow);
                    void'(out_q.pop_front());
                end
                void'(due_q.pop_front());
            end else begin
                chk("resp_quiet", b8.o_resp_valid, 2'b00);
            end
            done = (rq[0].size() == 0) && (rq[1].size() == 0) && (due_q.size() == 0) && (out_q.size() == 0);
            tick();
        end
        chk("engine_done", done, 1'b1);
        clear8();
    endtask

    initial begin
        int          got;
        int          acc;
        int          n_orph;
        int          bleft;
        int          out;
        int          max_out;
        int          nresp;
        bit          rv;
        int          t3_due[$];
        logic [7:0]  ord;

        clear8();
        clear2();

        // 1: reset held with all requesters valid
        nrst = 1'b0;
        b8.i_req_valid = 2'b11;
        b8.i_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("t1_req_valid", b8.o_req_valid, 1'b0);
            chk("t1_req_ready", b8.o_req_ready, 2'b00);
            chk("t1_cnt", dut8.cnt_q, 4'd0);
            chk("t1_orphan", b8.o_orphan, 1'b0);
        end
        clear8();
        nrst = 1'b1;
        tick();
        chk("t1_rr", dut8.rr_q, 1'b0);

        // 2: two 4-beat reads, one-cycle responses
        resp_log.delete();
        push_burst(0, 4, 32'h100, 1'b0);
        push_burst(1, 4, 32'h200, 1'b0);
        run_engine(100, 1, 1, 0, 200);
        ord = '0;
        for (int i = 0; i < resp_log.size() && i < 8; i++) ord[i] = resp_log[i][0];
        chk("t2_resp_count", resp_log.size(), 8);
        chk("t2_resp_order", ord, 8'hF0);
        chk("t2_rr_end", dut8.rr_q, 1'b0);

        // 3: MAX_OUTSTANDING=2, responses 10 cycles after each accept
        bleft = 4; out = 0; max_out = 0; nresp = 0; acc = 0;
        for (int i = 0; i < 80 && nresp < 4; i++) begin
            b2.i_req_valid[0] = (bleft > 0);
            b2.i_req_addr[0]  = 32'h300 + 32'(4 * (4 - bleft));
            b2.i_req_write[0] = 1'b1;
            b2.i_req_wdata[0] = $urandom;
            b2.i_req_last[0]  = (bleft == 1);
            b2.i_req_ready    = 1'b1;
            rv = (t3_due.size() > 0) && (t3_due[0] == cyc);
            b2.i_resp_valid = rv;
            #1;
            if (acc > 0 && bleft > 0) chk("t3_ready_gate", b2.o_req_ready[0], (out < 2));
            if (rv) chk("t3_resp", b2.o_resp_valid, 2'b01);
            if (b2.i_req_valid[0] && b2.o_req_ready[0]) begin
                acc++; bleft--; out++;
                t3_due.push_back(cyc + 10);
            end
            if (out > max_out) max_out = out;
            if (rv) begin
                void'(t3_due.pop_front());
                out--; nresp++;
            end
            tick();
        end
        chk("t3_all_resp", nresp, 4);
        chk("t3_max_out", max_out, 2);
        clear2();

        // 4: single-beat write answered in its accept cycle
        b8.i_req_valid[0] = 1'b1;
        b8.i_req_write[0] = 1'b1;
        b8.i_req_last[0]  = 1'b1;
        b8.i_req_addr[0]  = 32'h40;
        b8.i_req_ready    = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            #1;
            if (b8.o_req_valid) begin
                got = 1;
                b8.i_resp_valid = 1'b1;
                b8.i_resp_rdata = 32'hCAFE_0004;
                #1;
                chk("t4_resp_same", b8.o_resp_valid, 2'b01);
                chk("t4_rdata", b8.o_resp_rdata, 32'hCAFE_0004);
            end
            tick();
        end
        chk("t4_granted", got, 1);
        clear8();
        #1;
        chk("t4_drain_valid", b8.o_req_valid, 1'b0);
        chk("t4_drain_resp", b8.o_resp_valid, 2'b00);
        chk("t4_cnt", dut8.cnt_q, 4'd0);
        tick();
        chk("t4_rr_next", dut8.rr_q, 1'b1);
        chk("t4_no_orphan", b8.o_orphan, 1'b0);

        // 5: stray response while idle
        b8.i_resp_valid = 1'b1;
        #1;
        chk("t5_no_route", b8.o_resp_valid, 2'b00);
        chk("t5_orphan_lag", b8.o_orphan, 1'b0);
        tick();
        b8.i_resp_valid = 1'b0;
        chk("t5_orphan", b8.o_orphan, 1'b1);
        tick();
        chk("t5_orphan_end", b8.o_orphan, 1'b0);
        chk("t5_cnt", dut8.cnt_q, 4'd0);

        // 6: reset after 3 beats of an 8-beat burst; late responses become orphans
        b8.i_req_valid[1] = 1'b1;
        b8.i_req_addr[1]  = 32'h500;
        b8.i_req_ready    = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && acc < 3; i++) begin
            #1;
            if (b8.o_req_valid && b8.i_req_ready) acc++;
            if (acc < 3) tick();
        end
        chk("t6_accepts", acc, 3);
        tick();
        chk("t6_cnt_pre", dut8.cnt_q, 4'd3);
        nrst = 1'b0;
        #1;
        chk("t6_rst_gate", b8.o_req_valid, 1'b0);
        tick();
        nrst = 1'b1;
        clear8();
        chk("t6_cnt_clr", dut8.cnt_q, 4'd0);
        b8.i_req_valid[1] = 1'b1;
        #1;
        chk("t6_idle_valid", b8.o_req_valid, 1'b0);
        clear8();
        n_orph = 0;
        for (int k = 0; k < 3; k++) begin
            b8.i_resp_valid = 1'b1;
            #1;
            chk("t6_no_route", b8.o_resp_valid, 2'b00);
            tick();
            b8.i_resp_valid = 1'b0;
            if (b8.o_orphan === 1'b1) n_orph++;
            tick();
        end
        chk("t6_orphans", n_orph, 3);
        chk("t6_cnt_end", dut8.cnt_q, 4'd0);

        // randomized bursts, gaps, ready stalls and response delays
        m_owner = -1; m_rr = 0; mid[0] = 1'b0; mid[1] = 1'b0;
        out_q.delete(); due_q.delete();
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 5; n++)
                push_burst(r, $urandom_range(6, 1), 32'h1000 * (r + 1) + 32'(64 * n), 1'($urandom_range(1)));
        end
        run_engine(70, 1, 6, 25, 3000);
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < 3; n++)
                push_burst(r, $urandom_range(12, 4), 32'h8000 + 32'(256 * n), 1'($urandom_range(1)));
        end
        run_engine(100, 10, 14, 0, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
